// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control decoder with an iterative multiply/divide sequencer owning HI/LO.
// Define MD_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module alu_ctrl_md #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [5:0]        op_code,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [CODE_W-1:0] code,
  output logic              stall,
  output logic              busy,
  output logic              md_done,
  output logic              div_zero,
  output logic [1:0]        mf_sel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mc;
  logic [DATA_W-1:0]   mq;
  logic [DATA_W-1:0]   rs_raw;
  logic                is_div, neg_q, neg_r, dz;

  logic [3:0] code_raw;
  logic       r_type, md_op, mfhi, mflo, accept;
  logic       load, step, fin, last, run_done;

  // Decode
  always_comb begin
    code_raw = 4'b1111;
    case (ALUOp)
      2'b00: code_raw = 4'b0000;
      2'b01: code_raw = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: code_raw = 4'b0010;
          6'b100010: code_raw = 4'b0110;
          6'b100100: code_raw = 4'b0000;
          6'b100101: code_raw = 4'b0001;
          6'b101010: code_raw = 4'b0111;
          6'b100111: code_raw = 4'b1100;
          6'b100110: code_raw = 4'b1101;
          6'b101011: code_raw = 4'b1000;
          default:   code_raw = 4'b1111;
        endcase
      end
      default: begin
        case (op_code)
          6'b001100: code_raw = 4'b0000;
          6'b001101: code_raw = 4'b0001;
          6'b001010: code_raw = 4'b0111;
          6'b001110: code_raw = 4'b1101;
          default:   code_raw = 4'b1111;
        endcase
      end
    endcase
  end

  assign code   = CODE_W'(code_raw);
  assign r_type = valid_in & (ALUOp == 2'b10);
  assign md_op  = r_type & (funct[5:2] == 4'b0110);
  assign mfhi   = r_type & (funct == 6'b010000);
  assign mflo   = r_type & (funct == 6'b010010);
  assign mf_sel = {mflo, mfhi};
  assign stall  = busy & (md_op | mfhi | mflo);
  assign accept = md_op & ~busy;
  assign last   = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
`ifdef MD_EARLY_OUT_EN
    // mq still holds the bit consumed this cycle; the rest must be zero
    run_done = last | (~is_div & (mq[DATA_W-1:1] == '0));
`else
    run_done = last;
`endif
    case (state)
      ST_IDLE: if (accept) begin
        load     = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        step = 1'b1;
        if (run_done) state_nx = ST_FIX;
      end
      ST_FIX: begin
        fin      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Sequencer datapath: magnitudes in, signs applied in FIX
  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] abs_rs, abs_rt;
  logic [DATA_W:0]   dv_t, dv_d;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] quo, rem;

  assign rs_neg = ~funct[0] & rs_val[DATA_W-1];
  assign rt_neg = ~funct[0] & rt_val[DATA_W-1];
  assign abs_rs = rs_neg ? -rs_val : rs_val;
  assign abs_rt = rt_neg ? -rt_val : rt_val;
  assign dv_t   = acc[2*DATA_W-1:DATA_W-1];
  assign dv_d   = dv_t - {1'b0, mq};
  assign prod   = neg_q ? -acc : acc;
  assign quo    = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem    = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mc       <= '0;
      mq       <= '0;
      rs_raw   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      md_done  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy    <= (state_nx != ST_IDLE);
      md_done <= fin;
      if (load) begin
        cnt    <= '0;
        is_div <= funct[1];
        neg_q  <= rs_neg ^ rt_neg;
        neg_r  <= rs_neg;
        dz     <= funct[1] & (rt_val == '0);
        rs_raw <= rs_val;
        mq     <= abs_rt;
        mc     <= {{DATA_W{1'b0}}, abs_rs};
        acc    <= funct[1] ? {{DATA_W{1'b0}}, abs_rs} : '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          if (!dv_d[DATA_W]) acc <= {dv_d[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
          else               acc <= {dv_t[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end else begin
          if (mq[0]) acc <= acc + mc;
          mc <= mc << 1;
          mq <= mq >> 1;
        end
      end else if (fin) begin
        div_zero <= dz;
        if (!is_div) begin
          {hi, lo} <= prod;
        end else if (dz) begin
          hi <= rs_raw;
          lo <= '1;
        end else begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed self-checking bench for alu_ctrl_md (DATA_W=32, CODE_W=4).
module tb_alu_ctrl_md;

  logic        clk = 1'b0;
  logic        reset, valid_in;
  logic [1:0]  ALUOp;
  logic [5:0]  funct, op_code;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  code;
  logic        stall, busy, md_done, div_zero;
  logic [1:0]  mf_sel;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  alu_ctrl_md #(.DATA_W(32), .CODE_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp),
    .funct(funct), .op_code(op_code), .rs_val(rs_val), .rt_val(rt_val),
    .code(code), .stall(stall), .busy(busy), .md_done(md_done),
    .div_zero(div_zero), .mf_sel(mf_sel), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy cycles from acceptance to HI/LO write
  function automatic int exp_busy(input logic [5:0] f, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 33;
`ifdef MD_EARLY_OUT_EN
    if (!f[1]) begin
      m = (!f[0] && b[31]) ? -b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n == 0) n = 1;
      n = n + 1;
    end
`endif
    return n;
  endfunction

  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    int n;
    valid_in = 1'b1; ALUOp = 2'b10; funct = f; rs_val = a; rt_val = b;
    #1 check({tag, "_stall0"}, stall, 1'b0);
    tick();
    valid_in = 1'b0; rs_val = ~a; rt_val = ~b;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, exp_busy(f, b));
    check({tag, "_done"}, md_done, 1'b1);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_dz"}, div_zero, edz);
    tick();
    check({tag, "_done_pulse"}, md_done, 1'b0);
  endtask

  // {ALUOp, funct, op_code, code}
  logic [17:0] dec_tab [23] = '{
    {2'b00, 6'b100010, 6'b000000, 4'b0000},
    {2'b01, 6'b100000, 6'b000000, 4'b0110},
    {2'b10, 6'b100000, 6'b000000, 4'b0010},
    {2'b10, 6'b100010, 6'b000000, 4'b0110},
    {2'b10, 6'b100100, 6'b000000, 4'b0000},
    {2'b10, 6'b100101, 6'b000000, 4'b0001},
    {2'b10, 6'b101010, 6'b000000, 4'b0111},
    {2'b10, 6'b100111, 6'b000000, 4'b1100},
    {2'b10, 6'b100110, 6'b000000, 4'b1101},
    {2'b10, 6'b101011, 6'b000000, 4'b1000},
    {2'b10, 6'b011000, 6'b000000, 4'b1111},
    {2'b10, 6'b011001, 6'b000000, 4'b1111},
    {2'b10, 6'b011010, 6'b000000, 4'b1111},
    {2'b10, 6'b011011, 6'b000000, 4'b1111},
    {2'b10, 6'b010000, 6'b000000, 4'b1111},
    {2'b10, 6'b010010, 6'b000000, 4'b1111},
    {2'b10, 6'b000001, 6'b001100, 4'b1111},
    {2'b11, 6'b100000, 6'b001100, 4'b0000},
    {2'b11, 6'b100000, 6'b001101, 4'b0001},
    {2'b11, 6'b100000, 6'b001010, 4'b0111},
    {2'b11, 6'b100000, 6'b001110, 4'b1101},
    {2'b11, 6'b100000, 6'b000100, 4'b1111},
    {2'b11, 6'b100000, 6'b000000, 4'b1111}
  };

  initial begin
    logic ok;
    int   n;
    reset = 1'b1; valid_in = 1'b0; ALUOp = 2'b00; funct = '0; op_code = '0;
    rs_val = '0; rt_val = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", md_done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_mfsel", mf_sel, 2'b00);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 23; i++) begin
      logic [17:0] e;
      e = dec_tab[i];
      ALUOp = e[17:16]; funct = e[15:10]; op_code = e[9:4];
      #1 check($sformatf("dec%0d", i), code, e[3:0]);
    end

    run_md("mult",  6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_md("multu", 6'b011001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_md("div",   6'b011010, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md("divu0", 6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);
    run_md("div0s", 6'b011010, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run_md("divov", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_md("mul95", 6'b011000, 32'd9, 32'd5, 32'h0, 32'd45, 1'b0);

    // mflo and an add while a divide is in flight
    valid_in = 1'b1; ALUOp = 2'b10; funct = 6'b011010; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    valid_in = 1'b1; funct = 6'b100000;
    #1 check("add_busy_stall", stall, 1'b0);
    check("add_busy_code", code, 4'b0010);
    funct = 6'b010010;
    #1 check("mflo_stall", stall, 1'b1);
    ok = 1'b1; n = 0;
    while (busy && n < 200) begin
      if (!stall) ok = 1'b0;
      n++;
      tick();
    end
    check("mflo_stall_held", ok, 1'b1);
    check("mflo_release", stall, 1'b0);
    check("mflo_sel", mf_sel, 2'b10);
    check("mflo_lo", lo, 32'd14);
    check("mflo_hi", hi, 32'd2);
    valid_in = 1'b0;
    tick();

    // md op held through FIX is stalled, then accepted once idle
    valid_in = 1'b1; funct = 6'b011001; rs_val = 32'd2; rt_val = 32'd3;
    tick();
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("b2b_release", stall, 1'b0);
    rs_val = 32'd4; rt_val = 32'd6;
    tick();
    valid_in = 1'b0;
    check("b2b_accept", busy, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("b2b_lo", lo, 32'd24);

    // reset in the middle of a divide
    valid_in = 1'b1; funct = 6'b011011; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    check("mid_rst_done", md_done, 1'b0);
    reset = 1'b0;
    tick();
    run_md("mul35", 6'b011000, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
